full_adder: RTL and testbench

//   Registered full adder: Sum/Carry = A + B + C, built structurally from two half-adder cells
//   (XOR/AND) plus an OR for carry-out, with a synchronous output register.

---
 rtl/full_adder.sv | 60 ++++++
 tb/tb_full_adder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered ripple-carry full adder built from half-adder cells.
// {Carry, Sum} = A + B + C, one clock of latency, synchronous active-high reset.

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module full_adder #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
);
   logic [WIDTH:0]   chain;
   logic [WIDTH-1:0] sum_next;

   assign chain[0] = C;

   // Each bit cell: two half adders, carry-out is the OR of both half-adder carries.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic s1, c1, c2;

      half_adder ha1 (
         .x (A[i]),
         .y (B[i]),
         .s (s1),
         .c (c1)
      );

      half_adder ha2 (
         .x (s1),
         .y (chain[i]),
         .s (sum_next[i]),
         .c (c2)
      );

      assign chain[i+1] = c1 | c2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Sum   <= '0;
         Carry <= 1'b0;
      end else begin
         Sum   <= sum_next;
         Carry <= chain[WIDTH];
      end
   end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=4 against an arithmetic model.

module tb_full_adder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       c4 = 1'b0;
   logic       sum1, carry1;
   logic [3:0] sum4;
   logic       carry4;

   logic [1:0] exp1 = '0;
   logic [4:0] exp4 = '0;
   logic       valid = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .A     (a1),
      .B     (b1),
      .C     (c1),
      .Sum   (sum1),
      .Carry (carry1)
   );

   full_adder #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
      .A     (a4),
      .B     (b4),
      .C     (c4),
      .Sum   (sum4),
      .Carry (carry4)
   );

   task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Reference: the exact sum of the operands sampled at the edge, or zero under reset.
   always @(posedge clk) begin
      if (rst) begin
         exp1 <= '0;
         exp4 <= '0;
      end else begin
         exp1 <= 2'(a1) + 2'(b1) + 2'(c1);
         exp4 <= 5'(a4) + 5'(b4) + 5'(c4);
      end
      valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (valid) begin
         check("model_w1", {3'b0, carry1, sum1}, {3'b0, exp1});
         check("model_w4", {carry4, sum4}, exp4);
      end
   end

   task automatic drive1(input logic [2:0] v);
      @(negedge clk);
      {a1, b1, c1} = v;
   endtask

   task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
      @(negedge clk);
      a4 = a;
      b4 = b;
      c4 = c;
   endtask

   task automatic after_edge;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with all-ones inputs.
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         after_edge();
         check("reset_w1", {3'b0, carry1, sum1}, 5'd0);
         check("reset_w4", {carry4, sum4}, 5'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Exhaustive single-bit truth table.
      for (int v = 0; v < 8; v++) begin
         drive1(3'(v));
         after_edge();
         check($sformatf("truth_%0d", v), {3'b0, carry1, sum1}, {3'b0, tt[v]});
      end

      // Latency: previous vector 111 still visible until the next edge.
      drive1(3'b100);
      check("latency_before", {3'b0, carry1, sum1}, 5'b00011);
      after_edge();
      check("latency_after", {3'b0, carry1, sum1}, 5'b00001);

      // Reset mid-stream.
      drive1(3'b111);
      after_edge();
      check("mid_run", {3'b0, carry1, sum1}, 5'b00011);
      @(negedge clk);
      rst = 1'b1;
      after_edge();
      check("mid_reset", {3'b0, carry1, sum1}, 5'b00000);
      @(negedge clk);
      rst = 1'b0;
      after_edge();
      check("mid_release", {3'b0, carry1, sum1}, 5'b00011);

      // Four-bit directed vectors, including zero and full-scale boundaries.
      drive4(4'hF, 4'h1, 1'b0);
      after_edge();
      check("w4_f_1_0", {carry4, sum4}, 5'h10);
      drive4(4'hF, 4'hF, 1'b1);
      after_edge();
      check("w4_max", {carry4, sum4}, 5'h1F);
      drive4(4'h5, 4'hA, 1'b0);
      after_edge();
      check("w4_5_a_0", {carry4, sum4}, 5'h0F);
      drive4(4'h0, 4'h0, 1'b0);
      after_edge();
      check("w4_zero", {carry4, sum4}, 5'h00);

      // Random operands on both widths, one new vector per cycle.
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         a4 = 4'($urandom);
         b4 = 4'($urandom);
         c4 = 1'($urandom);
         {a1, b1, c1} = 3'($urandom);
         if (n % 97 == 13) rst = 1'b1;
         else rst = 1'b0;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
